// File: rtl/latency_mon_pkg.sv
// Shared types and defaults for the checkbits latency monitor.
// The log-entry struct describes the default-width layout of one logged run.
package latency_mon_pkg;

  // FSM states, also exported on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [7:0] DEFAULT_START_TAG = 8'hA5;
  localparam logic [7:0] DEFAULT_END_TAG   = 8'h5A;
  localparam int         DEFAULT_CNT_W     = 32;
  localparam int         DEFAULT_RESULT_W  = 8;

  typedef struct packed {
    logic                        timeout;
    logic [DEFAULT_RESULT_W-1:0] result;
    logic [DEFAULT_CNT_W-1:0]    cycles;
  } log_entry_t;

endpackage

// File: rtl/lat_log_ram.sv
// Run log: DEPTH-entry register file, synchronous write, registered read.
// The array is deliberately not reset so entries survive a monitor reset.
module lat_log_ram #(
  parameter int DEPTH  = 3,
  parameter int CYC_W  = 32,
  parameter int RES_W  = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [CYC_W-1:0]  wcycles,
  input  logic [RES_W-1:0]  wresult,
  input  logic              wtimeout,
  input  logic [ADDR_W-1:0] raddr,
  output logic [CYC_W-1:0]  rcycles,
  output logic [RES_W-1:0]  rresult,
  output logic              rtimeout
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [CYC_W-1:0] cyc_mem [DEPTH];
  logic [RES_W-1:0] res_mem [DEPTH];
  logic             to_mem  [DEPTH];

  logic waddr_ok;
  logic raddr_ok;

  assign waddr_ok = ({1'b0, waddr} < DEPTH_L);
  assign raddr_ok = ({1'b0, raddr} < DEPTH_L);

  always_ff @(posedge clock) begin
    if (we && waddr_ok) begin
      cyc_mem[waddr] <= wcycles;
      res_mem[waddr] <= wresult;
      to_mem[waddr]  <= wtimeout;
    end
  end

  // Non-blocking update means a same-address read sees the pre-write data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rcycles  <= '0;
      rresult  <= '0;
      rtimeout <= 1'b0;
    end else if (raddr_ok) begin
      rcycles  <= cyc_mem[raddr];
      rresult  <= res_mem[raddr];
      rtimeout <= to_mem[raddr];
    end else begin
      rcycles  <= '0;
      rresult  <= '0;
      rtimeout <= 1'b0;
    end
  end

endmodule

// File: rtl/checkbits_latency_monitor.sv
// Times start-tag to end-tag intervals on the firmware checkbits word and keeps
// per-run, min/max/total statistics plus a readable log of every run.
module checkbits_latency_monitor
  import latency_mon_pkg::*;
#(
  parameter int               DATA_W    = 16,
  parameter int               TAG_W     = 8,
  parameter logic [TAG_W-1:0] START_TAG = DEFAULT_START_TAG,
  parameter logic [TAG_W-1:0] END_TAG   = DEFAULT_END_TAG,
  parameter int               CNT_W     = 32,
  parameter int               NUM_RUNS  = 3,
  parameter int               TIMEOUT   = 250000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         clear,
  input  logic [DATA_W-1:0]            checkbits,
  output logic                         busy,
  output logic                         run_done,
  output logic [$clog2(NUM_RUNS+1)-1:0] run_idx,
  output logic [CNT_W-1:0]             run_cycles,
  output logic [DATA_W-TAG_W-1:0]      run_result,
  output logic [CNT_W+8-1:0]           total_cycles,
  output logic [CNT_W-1:0]             min_cycles,
  output logic [CNT_W-1:0]             max_cycles,
  output logic                         timeout_err,
  output logic                         all_done,
  input  logic [$clog2(NUM_RUNS)-1:0]  rd_addr,
  output logic [CNT_W-1:0]             rd_cycles,
  output logic [DATA_W-TAG_W-1:0]      rd_result,
  output logic                         rd_timeout,
  output state_t                       dbg_state
);

  localparam int                RES_W       = DATA_W - TAG_W;
  localparam int                IDX_W       = $clog2(NUM_RUNS + 1);
  localparam int                ADDR_W      = $clog2(NUM_RUNS);
  localparam int                TOT_W       = CNT_W + 8;
  localparam logic [DATA_W-1:0] START_WORD  = {{RES_W{1'b0}}, START_TAG};
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_RUNS - 1);

  state_t            state;
  logic [DATA_W-1:0] prev_bits;
  logic [CNT_W-1:0]  cnt;

  logic              start_hit;
  logic              end_hit;
  logic              timeout_hit;
  logic              run_end;
  logic [CNT_W-1:0]  log_cycles;
  logic [RES_W-1:0]  log_result;
  logic [TOT_W:0]    total_sum;

  // Start is edge-qualified so a held start word fires only once.
  assign start_hit   = (checkbits == START_WORD) && (prev_bits != START_WORD);
  assign end_hit     = (checkbits[TAG_W-1:0] == END_TAG);
  assign timeout_hit = (TIMEOUT != 0) && !end_hit && (cnt == TIMEOUT_CNT);
  assign run_end     = enable && !clear && (state == ST_MEASURE) && (end_hit || timeout_hit);

  assign log_cycles  = end_hit ? cnt : TIMEOUT_CNT;
  assign log_result  = end_hit ? checkbits[DATA_W-1:TAG_W] : '0;
  assign total_sum   = {1'b0, total_cycles} + (TOT_W + 1)'(cnt);

  assign busy        = (state == ST_MEASURE);
  assign dbg_state   = state;

  // Reset value is the start pattern so a tag already present is not an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_bits <= START_WORD;
    end else begin
      prev_bits <= checkbits;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      run_done     <= 1'b0;
      run_idx      <= '0;
      run_cycles   <= '0;
      run_result   <= '0;
      total_cycles <= '0;
      min_cycles   <= '1;
      max_cycles   <= '0;
      timeout_err  <= 1'b0;
      all_done     <= 1'b0;
    end else begin
      run_done <= 1'b0;
      if (clear) begin
        // Clear wins over everything, including an end tag on this edge.
        state        <= enable ? ST_ARMED : ST_IDLE;
        cnt          <= '0;
        run_idx      <= '0;
        run_cycles   <= '0;
        run_result   <= '0;
        total_cycles <= '0;
        min_cycles   <= '1;
        max_cycles   <= '0;
        timeout_err  <= 1'b0;
        all_done     <= 1'b0;
      end else if (!enable) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= all_done ? ST_DONE : ST_ARMED;
          end
          ST_ARMED: begin
            if (start_hit) begin
              state <= ST_MEASURE;
              cnt   <= CNT_W'(1);
            end
          end
          ST_MEASURE: begin
            if (run_end) begin
              run_done   <= 1'b1;
              run_cycles <= log_cycles;
              run_result <= log_result;
              run_idx    <= run_idx + IDX_W'(1);
              if (end_hit) begin
                total_cycles <= total_sum[TOT_W] ? '1 : total_sum[TOT_W-1:0];
                if (cnt < min_cycles) min_cycles <= cnt;
                if (cnt > max_cycles) max_cycles <= cnt;
              end else begin
                timeout_err <= 1'b1;
              end
              if (run_idx == LAST_IDX) begin
                state    <= ST_DONE;
                all_done <= 1'b1;
              end else begin
                state <= ST_ARMED;
              end
            end else if (cnt != '1) begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_DONE: begin
            state <= ST_DONE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  lat_log_ram #(
    .DEPTH  (NUM_RUNS),
    .CYC_W  (CNT_W),
    .RES_W  (RES_W),
    .ADDR_W (ADDR_W)
  ) u_log (
    .clock    (clock),
    .reset    (reset),
    .we       (run_end),
    .waddr    (ADDR_W'(run_idx)),
    .wcycles  (log_cycles),
    .wresult  (log_result),
    .wtimeout (timeout_hit),
    .raddr    (rd_addr),
    .rcycles  (rd_cycles),
    .rresult  (rd_result),
    .rtimeout (rd_timeout)
  );

endmodule

// File: doc/checkbits_latency_monitor.md
# checkbits_latency_monitor

- Parametrised, synthesizable latency monitor for the user-project debug path.
- Watches the `checkbits` word driven onto mprj_io[31:16] by firmware. It times each start-tag to end-tag interval and captures the result field.
- Keeps per-run, min, max and total statistics over a configurable number of runs, logs every run in a readable buffer, and flags runs that time out.
- Sits beside the FIR user project so cycle counts are available as hardware registers as well as in simulation printouts.

## Interface
Parameters:
- DATA_W, 16, width of checkbits
- TAG_W, 8, width of the tag field (checkbits[TAG_W-1:0]); result field is checkbits[DATA_W-1:TAG_W]
- START_TAG, 8'hA5, start marker; the whole word must equal {0, START_TAG}
- END_TAG, 8'h5A, end marker; only the tag field is compared
- CNT_W, 32, cycle counter width
- NUM_RUNS, 3, runs per session; also the log depth
- TIMEOUT, 250000, per-run cycle limit; 0 disables

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  monitor armed while high
- clear  in  1  synchronous pulse; clears stats, log index, flags
- checkbits  in  DATA_W  observed debug word
- busy  out  1  high in MEASURE
- run_done  out  1  one-cycle pulse per completed or timed-out run
- run_idx  out  $clog2(NUM_RUNS+1)  runs completed this session
- run_cycles  out  CNT_W  latency of last run
- run_result  out  DATA_W-TAG_W  result field captured at end tag
- total_cycles  out  CNT_W+8  saturating sum of valid runs
- min_cycles / max_cycles  out  CNT_W  extremes over valid runs
- timeout_err  out  1  sticky; set by any timed-out run
- all_done  out  1  high once run_idx == NUM_RUNS
- rd_addr  in  $clog2(NUM_RUNS)  log read address
- rd_cycles / rd_result / rd_timeout  out  CNT_W / DATA_W-TAG_W / 1  log entry

## Operation
- States: IDLE, ARMED, MEASURE, DONE.
- IDLE → ARMED when enable=1.
- ARMED:
  - Start is edge-qualified: checkbits == {0,START_TAG} this cycle, and the previous sample was not. A start tag held high triggers exactly once.
  - On start: go to MEASURE, counter loads 1.
- MEASURE, each cycle:
  - If the tag field == END_TAG: capture counter into run_cycles and the result field into run_result. Write the log entry at index run_idx with timeout=0. Update min, max and total, pulse run_done, increment run_idx.
  - Otherwise increment the counter; it saturates at all-ones.
- Latency definition: an end tag sampled k edges after the start edge gives run_cycles = k.
- Timeout: the counter reaches TIMEOUT (TIMEOUT ≠ 0) without an end tag.
  - Log an entry with cycles = TIMEOUT and timeout=1, set timeout_err, pulse run_done, increment run_idx.
  - Min, max and total are not updated.
- After a run: go to ARMED if run_idx < NUM_RUNS, else DONE with all_done=1.
- DONE holds until clear or reset.
- enable=0 in any state → IDLE. A run in progress is aborted, nothing is logged, and stats are kept.
- clear has priority over every other event, including a simultaneous end tag; that run is discarded.
  - After clear: stats and log index are zeroed, min = all-ones, flags = 0.
  - Next state is ARMED if enable=1, else IDLE. Log contents are not cleared.
- total_cycles saturates at all-ones.

## Timing
- Reset values:
  - State IDLE; all outputs 0 except min_cycles, which resets to all-ones.
  - The previous-sample register resets to the start pattern, so a tag already present at reset does not trigger.
- run_cycles, run_result, statistics and run_done update on the same edge that samples the end tag. They are registered outputs, visible the following cycle.
- Log read: rd_* registered, 1-cycle latency from rd_addr.
- Log write and a same-address read in the same cycle: the read returns the old data.
- Reset mid-run: immediate return to IDLE. The log array itself is not reset.
- checkbits is treated as synchronous to clock; synchronising it is the integrator's job.

## Structure
- Package `latency_mon_pkg`:
  - state enum
  - default START_TAG / END_TAG constants
  - log-entry struct {timeout, result, cycles}
- Sub-module `lat_log_ram`:
  - NUM_RUNS-deep register file of log entries
  - synchronous write, registered read, no reset on the array
- Top module holds the FSM, counter, edge detect and statistics.

## Test plan
- Three runs at latencies 100, 200, 300 with results 8'h11, 8'h22, 8'h33:
  - run_cycles per run 100 / 200 / 300; total 600; min 100; max 300; all_done=1; log reads match.
- Start tag held steady for 50 cycles, end tag 120 cycles after the first start: exactly one run_done, run_cycles = 120.
- TIMEOUT=50, no end tag: run_done at 50 cycles; timeout_err=1; rd_timeout=1; min stays all-ones; total stays 0.
- enable dropped mid-run, then a new run of 40 cycles: no log entry for the aborted run; run_idx = 1; run_cycles = 40.
- clear asserted on the same cycle as the end tag: run discarded; run_idx = 0; state ARMED.
- reset asserted mid-MEASURE: all outputs return to reset values asynchronously; a subsequent 10-cycle run reports 10.
